// File: rtl/float_round_pack_pkg.sv
// Shared types and constants for the binary32 round/pack stage.
// Holds the rounding-mode codes, the fflags bit positions and the stage-1 register layout.
package float_round_pack_pkg;
   localparam int FP_MAN_W = 24;
   localparam int FP_EXP_W = 10;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   localparam int FFLAG_NX = 0;
   localparam int FFLAG_UF = 1;
   localparam int FFLAG_OF = 2;
   localparam int FFLAG_DZ = 3;
   localparam int FFLAG_NV = 4;

   typedef struct packed {
      logic                sgn;
      logic [FP_EXP_W-1:0] exp;
      logic [FP_MAN_W-1:0] man;
      logic                rb;
      logic                st;
      logic                skip;
      logic                iv;
      logic                dz;
      logic [2:0]          rm;
      logic                tiny;
      logic                no_uf;
   } s1_t;

   // Unknown mode codes fall through to round-to-nearest-even.
   function automatic logic round_inc(input logic [2:0] rm, input logic sgn,
                                      input logic lsb, input logic rb, input logic st);
      case (rm)
         RM_RTZ:  return 1'b0;
         RM_RDN:  return (rb | st) & sgn;
         RM_RUP:  return (rb | st) & ~sgn;
         RM_RMM:  return rb;
         default: return rb & (st | lsb);
      endcase
   endfunction
endpackage

// File: rtl/float_shift_sticky.sv
// Right shift of a {man, round, sticky} vector; every bit shifted out lands in bit 0.
// Amounts beyond the vector width clamp to a full flush into sticky.
module float_shift_sticky #(
   parameter int W    = 26,
   parameter int SH_W = 11
) (
   input  logic [W-1:0]    data_i,
   input  logic [SH_W-1:0] sh_i,
   output logic [W-1:0]    data_o
);
   localparam int CW = $clog2(W + 1);

   logic [CW-1:0]  sh_c;
   logic [2*W-1:0] wide;

   assign sh_c   = (sh_i > SH_W'(W)) ? CW'(W) : sh_i[CW-1:0];
   assign wide   = {data_i, {W{1'b0}}} >> sh_c;
   assign data_o = {wide[2*W-1:W+1], wide[W] | (|wide[W-1:0])};
endmodule

// File: rtl/float_round_pack.sv
// Two-stage round-and-pack of an unrounded FPU result into binary32 plus fflags.
// Stage 1 denormalises subnormal-range results; stage 2 rounds, flags and packs.
module float_round_pack
   import float_round_pack_pkg::*;
#(
   parameter int MAN_W = FP_MAN_W,
   parameter int EXP_W = FP_EXP_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             valid_in,
   output logic             ready_out,
   output logic             valid_out,
   input  logic             ready_in,
   input  logic [2:0]       rm,
   input  logic [MAN_W-1:0] man_in,
   input  logic [EXP_W-1:0] exp_in,
   input  logic             sgn_in,
   input  logic             round_bit,
   input  logic             sticky_bit,
   input  logic             skip_round,
   input  logic             IV,
   input  logic             DZ,
   output logic [31:0]      float_out,
   output logic [4:0]       fflags
);
   logic        s1_valid_q, s2_valid_q, s1_adv, s2_adv;
   s1_t         s1_d, s1_q;
   logic [31:0] float_q, res_d;
   logic [4:0]  fflags_q, flg_d;

   assign s2_adv    = !s2_valid_q || ready_in;
   assign s1_adv    = !s1_valid_q || s2_adv;
   assign ready_out = s1_adv;
   assign valid_out = s2_valid_q;
   assign float_out = float_q;
   assign fflags    = fflags_q;

   logic             sub_range;
   logic [EXP_W:0]   sh;
   logic [MAN_W+1:0] shifted;

   assign sub_range = !skip_round && (exp_in[EXP_W-1] || exp_in == '0);
   assign sh        = (EXP_W+1)'(1) - {exp_in[EXP_W-1], exp_in};

   float_shift_sticky #(.W(MAN_W+2), .SH_W(EXP_W+1)) u_shift (
      .data_i ({man_in, round_bit, sticky_bit}),
      .sh_i   (sh),
      .data_o (shifted)
   );

   always_comb begin
      s1_d      = '0;
      s1_d.sgn  = sgn_in;
      s1_d.rm   = rm;
      s1_d.skip = skip_round;
      s1_d.iv   = IV;
      s1_d.dz   = DZ;
      // Rounding the unshifted mantissa up to 2^-126 means not tiny after rounding.
      s1_d.no_uf = (exp_in == '0) && (&man_in)
                   && round_inc(rm, sgn_in, man_in[0], round_bit, sticky_bit);
      if (sub_range) begin
         s1_d.exp                    = '0;
         {s1_d.man, s1_d.rb, s1_d.st} = shifted;
         s1_d.tiny                   = 1'b1;
      end else begin
         s1_d.exp = exp_in;
         s1_d.man = man_in;
         s1_d.rb  = round_bit;
         s1_d.st  = sticky_bit;
      end
   end

   logic           inc, nx, of, max_fin;
   logic [MAN_W:0] sum;
   logic [EXP_W:0] exp_r;

   always_comb begin
      inc   = round_inc(s1_q.rm, s1_q.sgn, s1_q.man[0], s1_q.rb, s1_q.st);
      sum   = {1'b0, s1_q.man} + {{MAN_W{1'b0}}, inc};
      // Mantissa carry-out bumps the exponent; a subnormal reaching bit 23 becomes exponent 1.
      exp_r = {s1_q.exp[EXP_W-1], s1_q.exp} + {{EXP_W{1'b0}}, sum[MAN_W]}
              + {{EXP_W{1'b0}}, s1_q.tiny & sum[MAN_W-1]};
      nx      = s1_q.rb | s1_q.st;
      of      = !exp_r[EXP_W] && (exp_r >= (EXP_W+1)'(255));
      max_fin = (s1_q.rm == RM_RTZ) || (s1_q.rm == RM_RDN && !s1_q.sgn)
                || (s1_q.rm == RM_RUP && s1_q.sgn);
      res_d   = {s1_q.sgn, exp_r[7:0], sum[MAN_W] ? 23'd0 : sum[22:0]};
      flg_d           = '0;
      flg_d[FFLAG_NV] = s1_q.iv;
      flg_d[FFLAG_DZ] = s1_q.dz;
      if (s1_q.skip) begin
         res_d = {s1_q.sgn, s1_q.exp[7:0], s1_q.man[22:0]};
      end else begin
         flg_d[FFLAG_NX] = nx;
         flg_d[FFLAG_UF] = nx & s1_q.tiny & ~s1_q.no_uf;
         if (of) begin
            flg_d[FFLAG_OF] = 1'b1;
            res_d = max_fin ? {s1_q.sgn, 31'h7F7FFFFF} : {s1_q.sgn, 31'h7F800000};
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_q       <= '0;
         float_q    <= '0;
         fflags_q   <= '0;
      end else if (flush) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         float_q    <= '0;
         fflags_q   <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid_q <= valid_in;
            if (valid_in) s1_q <= s1_d;
         end
         if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               float_q  <= res_d;
               fflags_q <= flg_d;
            end
         end
      end
   end
endmodule

// File: tb/tb_float_round_pack.sv
// Scoreboard bench for float_round_pack: directed vectors push expected words,
// a negedge monitor pops and compares every delivered result.
module tb_float_round_pack;
   import float_round_pack_pkg::*;

   logic        clk = 1'b0;
   logic        reset, flush, valid_in, ready_out, valid_out, ready_in;
   logic        sgn_in, round_bit, sticky_bit, skip_round, IV, DZ;
   logic [2:0]  rm;
   logic [23:0] man_in;
   logic [9:0]  exp_in;
   logic [31:0] float_out;
   logic [4:0]  fflags;

   always #5 clk = ~clk;

   float_round_pack dut (
      .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .ready_out(ready_out),
      .valid_out(valid_out), .ready_in(ready_in), .rm(rm), .man_in(man_in), .exp_in(exp_in),
      .sgn_in(sgn_in), .round_bit(round_bit), .sticky_bit(sticky_bit), .skip_round(skip_round),
      .IV(IV), .DZ(DZ), .float_out(float_out), .fflags(fflags)
   );

   typedef struct {
      logic [2:0]  rm;
      logic [23:0] man;
      logic [9:0]  exp;
      logic        sgn, rb, st, skip, iv, dz;
      logic [31:0] ef;
      logic [4:0]  efl;
   } vec_t;

   typedef struct {
      int          id;
      logic [31:0] f;
      logic [4:0]  fl;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t dir[$];
   vec_t bp[4];
   int   n_chk = 0, n_err = 0, id_ctr = 0;

   function automatic vec_t mk(input logic [2:0] r, input logic [23:0] m, input logic [9:0] e,
                               input logic s, input logic rb, input logic st, input logic sk,
                               input logic iv, input logic dz, input logic [31:0] ef,
                               input logic [4:0] efl);
      vec_t v;
      v.rm = r; v.man = m; v.exp = e; v.sgn = s; v.rb = rb; v.st = st;
      v.skip = sk; v.iv = iv; v.dz = dz; v.ef = ef; v.efl = efl;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [37:0] act, input logic [37:0] want);
      n_chk++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", nm, act, want);
      end
   endtask

   task automatic drive(input vec_t v);
      rm = v.rm; man_in = v.man; exp_in = v.exp; sgn_in = v.sgn; round_bit = v.rb;
      sticky_bit = v.st; skip_round = v.skip; IV = v.iv; DZ = v.dz;
   endtask

   task automatic push(input vec_t v);
      exp_t e;
      e.id = id_ctr; e.f = v.ef; e.fl = v.efl;
      sb.push_back(e);
      id_ctr++;
   endtask

   // Returns one time unit after the accepting edge; valid_in is left high.
   task automatic send(input vec_t v);
      bit acc;
      int w;
      drive(v);
      valid_in = 1'b1;
      acc = 1'b0;
      w = 0;
      while (!acc && w < 40) begin
         #1;
         acc = ready_out;
         @(posedge clk);
         #1;
         w++;
      end
      if (acc) push(v);
      else begin
         n_chk++; n_err++;
         $display("FAIL accept timeout: ready_out stayed 0 for %0d cycles, want 1", w);
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 100) begin
         @(posedge clk);
         w++;
      end
      #1;
      chk("drain", 38'(sb.size()), 38'd0);
   endtask

   always @(negedge clk) begin
      if (!reset && valid_out && ready_in) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected output: float_out=%h fflags=%b, want none", float_out, fflags);
         end else begin
            mon_e = sb.pop_front();
            if (float_out !== mon_e.f || fflags !== mon_e.fl) begin
               n_err++;
               $display("FAIL vec%0d: float_out=%h fflags=%b, want %h %b",
                        mon_e.id, float_out, fflags, mon_e.f, mon_e.fl);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want completion");
      $fatal(1);
   end

   initial begin
      bit acc;
      int idx;
      vec_t v1, fa, fb, fc, fd;

      reset = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
      drive(mk(RM_RNE, 24'h0, 10'h0, 0, 0, 0, 0, 0, 0, 32'h0, 5'h0));
      #12;
      chk("reset outputs", 38'({valid_out, float_out, fflags}), 38'd0);
      chk("reset ready_out", 38'(ready_out), 38'd1);
      reset = 1'b0;
      @(posedge clk); #1;

      // Two-cycle latency on an empty pipeline
      v1 = mk(RM_RNE, 24'hC00000, 10'd127, 0, 0, 0, 0, 0, 0, 32'h3FC00000, 5'b00000);
      send(v1);
      valid_in = 1'b0;
      chk("latency 1 cycle", 38'(valid_out), 38'd0);
      @(posedge clk); #1;
      chk("latency 2 cycles", 38'(valid_out), 38'd1);
      drain();

      dir.push_back(mk(RM_RNE, 24'h800001, 10'd127, 0, 1, 0, 0, 0, 0, 32'h3F800002, 5'b00001));
      dir.push_back(mk(RM_RNE, 24'h800000, 10'd127, 0, 1, 0, 0, 0, 0, 32'h3F800000, 5'b00001));
      dir.push_back(mk(RM_RNE, 24'hFFFFFF, 10'd254, 0, 1, 0, 0, 0, 0, 32'h7F800000, 5'b00101));
      // RTZ truncates to the largest finite value without leaving the range: inexact only
      dir.push_back(mk(RM_RTZ, 24'hFFFFFF, 10'd254, 0, 1, 0, 0, 0, 0, 32'h7F7FFFFF, 5'b00001));
      dir.push_back(mk(RM_RTZ, 24'h800000, 10'd255, 0, 1, 0, 0, 0, 0, 32'h7F7FFFFF, 5'b00101));
      dir.push_back(mk(RM_RDN, 24'hFFFFFF, 10'd254, 1, 1, 0, 0, 0, 0, 32'hFF800000, 5'b00101));
      dir.push_back(mk(RM_RUP, 24'h800000, 10'd255, 1, 1, 0, 0, 0, 0, 32'hFF7FFFFF, 5'b00101));
      dir.push_back(mk(RM_RNE, 24'h800000, 10'h000, 0, 0, 0, 0, 0, 0, 32'h00400000, 5'b00000));
      dir.push_back(mk(RM_RNE, 24'h800000, 10'h3EA, 0, 0, 0, 0, 0, 0, 32'h00000001, 5'b00000));
      dir.push_back(mk(RM_RNE, 24'h800000, 10'h3E2, 0, 0, 0, 0, 0, 0, 32'h00000000, 5'b00011));
      dir.push_back(mk(RM_RUP, 24'h800000, 10'h3E2, 0, 0, 0, 0, 0, 0, 32'h00000001, 5'b00011));
      dir.push_back(mk(RM_RNE, 24'hFFFFFF, 10'h000, 0, 1, 0, 0, 0, 0, 32'h00800000, 5'b00001));
      dir.push_back(mk(RM_RNE, 24'h800001, 10'h000, 0, 0, 0, 0, 0, 0, 32'h00400000, 5'b00011));
      dir.push_back(mk(RM_RNE, 24'h800000, 10'd1,   0, 0, 0, 0, 0, 0, 32'h00800000, 5'b00000));
      dir.push_back(mk(RM_RNE, 24'hC00000, 10'h0FF, 0, 1, 0, 1, 1, 0, 32'h7FC00000, 5'b10000));
      dir.push_back(mk(RM_RNE, 24'h800000, 10'h0FF, 1, 0, 0, 1, 0, 1, 32'hFF800000, 5'b01000));
      dir.push_back(mk(RM_RMM, 24'h800000, 10'd127, 0, 1, 0, 0, 0, 0, 32'h3F800001, 5'b00001));
      dir.push_back(mk(RM_RDN, 24'h800000, 10'd127, 1, 0, 1, 0, 0, 0, 32'hBF800001, 5'b00001));
      dir.push_back(mk(3'b101, 24'h800001, 10'd127, 0, 1, 0, 0, 0, 0, 32'h3F800002, 5'b00001));
      foreach (dir[i]) send(dir[i]);
      valid_in = 1'b0;
      drain();

      // Stall: two accepts fill both stages, then ready_out must stay low
      for (int i = 0; i < 4; i++)
         bp[i] = mk(RM_RNE, 24'h800000 + 24'(i), 10'd100 + 10'(i), 0, 0, 0, 0, 0, 0,
                    {1'b0, 8'd100 + 8'(i), 23'(i)}, 5'b00000);
      ready_in = 1'b0;
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         drive(bp[idx]);
         valid_in = 1'b1;
         #1;
         acc = ready_out;
         if (c >= 2) begin
            chk("stall ready_out", 38'(ready_out), 38'd0);
            chk("stall hold", 38'({valid_out, float_out, fflags}), 38'({1'b1, bp[0].ef, bp[0].efl}));
         end
         @(posedge clk); #1;
         if (acc) begin
            push(bp[idx]);
            idx++;
         end
      end
      chk("stall accepts", 38'(idx), 38'd2);
      ready_in = 1'b1;
      for (int i = 2; i < 4; i++) send(bp[i]);
      valid_in = 1'b0;
      drain();

      // Flush with both stages full, then flush racing a fresh input
      fa = mk(RM_RNE, 24'hA00000, 10'd130, 0, 0, 0, 0, 0, 0, 32'h41200000, 5'b00000);
      fb = mk(RM_RNE, 24'hB00000, 10'd131, 0, 0, 0, 0, 0, 0, 32'h41B00000, 5'b00000);
      fc = mk(RM_RNE, 24'hC00000, 10'd132, 0, 0, 0, 0, 0, 0, 32'h42400000, 5'b00000);
      fd = mk(RM_RNE, 24'h900000, 10'd126, 1, 0, 0, 0, 0, 0, 32'hBF100000, 5'b00000);
      ready_in = 1'b0;
      send(fa);
      send(fb);
      drive(fc);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      valid_in = 1'b0;
      sb.delete();
      chk("flush outputs", 38'({valid_out, float_out, fflags}), 38'd0);
      chk("flush ready_out", 38'(ready_out), 38'd1);
      valid_in = 1'b1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      valid_in = 1'b0;
      ready_in = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("post-flush idle", 38'(valid_out), 38'd0);
      send(fd);
      valid_in = 1'b0;
      drain();

      // Asynchronous reset mid-stream
      send(fa);
      send(fb);
      valid_in = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      chk("async reset outputs", 38'({valid_out, float_out, fflags}), 38'd0);
      sb.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      chk("reset release ready_out", 38'(ready_out), 38'd1);
      send(fd);
      valid_in = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule
